xrad_link_rx: RTL and testbench

// - Receive end of the XRAD high-speed output link. Captures each 64-bit word on hs_data/hs_valid
//   and splits it into ai_result [63:32] and rt_output [31:0].
// - Tags each accepted word with a sequence number and buffers it in a FIFO for a valid/ready consumer.
// - The link has no backpressure, so a full FIFO drops words. Drops are counted, and link liveness
//   is tracked with an inactivity watchdog.

---
 rtl/xrad_pkg.sv | 18 +
 rtl/xrad_sync_fifo.sv | 69 ++++++
 rtl/xrad_link_rx.sv | 127 ++++++++++++
 tb/tb_xrad_link_rx.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/xrad_pkg.sv
// Shared types and constants for the XRAD output link receiver.
package xrad_pkg;

  localparam int XRAD_AI_MSB = 63;
  localparam int XRAD_AI_LSB = 32;

  typedef struct packed {
    logic [31:0] ai_result;
    logic [31:0] rt_output;
  } xrad_link_word_t;

  typedef enum logic [1:0] {
    LINK_IDLE    = 2'd0,
    LINK_ACTIVE  = 2'd1,
    LINK_STALLED = 2'd2
  } xrad_link_state_t;

endpackage

// File: rtl/xrad_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head.
// The head register and valid flag are loaded from the next read slot, or from din when the FIFO drains to empty.
module xrad_sync_fifo
  import xrad_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      rd_ptr_nxt;
  logic [AW:0]      remain;
  logic             do_push;
  logic             do_pop;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop     = pop && valid;
  assign do_push    = push && (!full || do_pop);
  assign rd_ptr_nxt = rd_ptr + (AW+1)'(do_pop);
  assign remain     = level - (AW+1)'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // Entries left after the pop come from storage; otherwise a same-cycle push becomes the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      dout   <= '0;
      valid  <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      rd_ptr <= rd_ptr_nxt;
      level  <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (remain != '0) begin
        dout  <= mem[rd_ptr_nxt[AW-1:0]];
        valid <= 1'b1;
      end else if (do_push) begin
        dout  <= din;
        valid <= 1'b1;
      end else begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/xrad_link_rx.sv
// Receive end of the XRAD output link: splits, sequence-tags and buffers link words,
// counts drops on overflow and tracks link liveness with an inactivity watchdog.
module xrad_link_rx
  import xrad_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16,
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1,
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      hs_data,
  input  logic             hs_valid,
  output logic [31:0]      out_ai,
  output logic [31:0]      out_rt,
  output logic [CNT_W-1:0] out_seq,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LVL_W-1:0] fifo_level,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             ovf_sticky,
  input  logic             clr_stats,
  output logic             link_alive
);

  xrad_link_word_t  in_word;
  xrad_link_word_t  head_word;
  xrad_link_state_t state;
  xrad_link_state_t state_nxt;
  logic [CNT_W-1:0] seq_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             push;
  logic             drop;

  assign in_word.ai_result = hs_data[XRAD_AI_MSB:XRAD_AI_LSB];
  assign in_word.rt_output = hs_data[XRAD_AI_LSB-1:0];

  assign pop  = out_valid && out_ready && !fifo_empty;
  assign push = hs_valid && (!fifo_full || pop);
  assign drop = hs_valid && fifo_full && !pop;

  xrad_sync_fifo #(
    .WIDTH (64 + CNT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({in_word, seq_cnt}),
    .pop   (pop),
    .dout  ({head_word, out_seq}),
    .valid (out_valid),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign out_ai = head_word.ai_result;
  assign out_rt = head_word.rt_output;

  // Dropped words never consume a sequence number.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_cnt <= '0;
    end else if (push) begin
      seq_cnt <= seq_cnt + CNT_W'(1);
    end
  end

  // clr_stats takes priority over a drop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt   <= '0;
      ovf_sticky <= 1'b0;
    end else if (clr_stats) begin
      drop_cnt   <= '0;
      ovf_sticky <= 1'b0;
    end else if (drop) begin
      if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
      ovf_sticky <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt   <= '0;
      state      <= LINK_IDLE;
      link_alive <= 1'b0;
    end else begin
      if (hs_valid) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_W'(TIMEOUT_CYC)) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
      state      <= state_nxt;
      link_alive <= (state_nxt == LINK_ACTIVE);
    end
  end

  // Stall after TIMEOUT_CYC consecutive quiet cycles in ACTIVE.
  always_comb begin
    state_nxt = state;
    case (state)
      LINK_IDLE: begin
        if (hs_valid) state_nxt = LINK_ACTIVE;
        else          state_nxt = LINK_IDLE;
      end
      LINK_ACTIVE: begin
        if (!hs_valid && (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1))) state_nxt = LINK_STALLED;
        else                                                    state_nxt = LINK_ACTIVE;
      end
      LINK_STALLED: begin
        if (hs_valid) state_nxt = LINK_ACTIVE;
        else          state_nxt = LINK_STALLED;
      end
      default: state_nxt = LINK_IDLE;
    endcase
  end

endmodule

// File: tb/tb_xrad_link_rx.sv
// Directed self-checking bench for xrad_link_rx with FIFO_DEPTH=8, TIMEOUT_CYC=16.
module tb_xrad_link_rx;

  logic        clk;
  logic        rst;
  logic [63:0] hs_data;
  logic        hs_valid;
  logic [31:0] out_ai;
  logic [31:0] out_rt;
  logic [15:0] out_seq;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  fifo_level;
  logic [15:0] drop_cnt;
  logic        ovf_sticky;
  logic        clr_stats;
  logic        link_alive;

  int checks = 0;
  int errors = 0;

  xrad_link_rx #(
    .FIFO_DEPTH  (8),
    .TIMEOUT_CYC (16),
    .CNT_W       (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hs_data    (hs_data),
    .hs_valid   (hs_valid),
    .out_ai     (out_ai),
    .out_rt     (out_rt),
    .out_seq    (out_seq),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt),
    .ovf_sticky (ovf_sticky),
    .clr_stats  (clr_stats),
    .link_alive (link_alive)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; hs_valid = 1'b0; hs_data = 64'd0; out_ready = 1'b0; clr_stats = 1'b0;
    tick(); tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_level", fifo_level, 4'd0);
    chk("rst_drop", drop_cnt, 16'd0);
    chk("rst_ovf", ovf_sticky, 1'b0);
    chk("rst_alive", link_alive, 1'b0);
    chk("rst_ai", out_ai, 32'd0);
    chk("rst_seq", out_seq, 16'd0);
    rst = 1'b0;
    tick();

    // Single word with consumer ready
    out_ready = 1'b1; hs_data = 64'hDEADBEEF_12345678; hs_valid = 1'b1;
    tick();
    hs_valid = 1'b0; hs_data = 64'd0;
    chk("single_valid", out_valid, 1'b1);
    chk("single_ai", out_ai, 32'hDEADBEEF);
    chk("single_rt", out_rt, 32'h12345678);
    chk("single_seq", out_seq, 16'd0);
    chk("wd_alive_after_word", link_alive, 1'b1);
    tick();
    chk("single_valid_gone", out_valid, 1'b0);
    chk("single_ai_hold", out_ai, 32'hDEADBEEF);

    // Watchdog: 16 quiet cycles after the last hs_valid
    repeat (14) tick();
    chk("wd_alive_15", link_alive, 1'b1);
    tick();
    chk("wd_stalled_16", link_alive, 1'b0);
    hs_valid = 1'b1; hs_data = 64'h11111111_22222222;
    tick();
    hs_valid = 1'b0;
    chk("wd_realive", link_alive, 1'b1);
    chk("second_seq", out_seq, 16'd1);

    // Overflow: 10 words into a depth-8 FIFO with no consumer
    rst = 1'b1; #1; rst = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      hs_data = {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)};
      hs_valid = 1'b1;
      tick();
    end
    chk("ovf_level", fifo_level, 4'd8);
    chk("ovf_drop", drop_cnt, 16'd2);
    chk("ovf_sticky", ovf_sticky, 1'b1);
    chk("ovf_head_seq", out_seq, 16'd0);

    // clr_stats in the same cycle as a drop
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0; hs_valid = 1'b0;
    chk("clr_drop", drop_cnt, 16'd0);
    chk("clr_ovf", ovf_sticky, 1'b0);
    chk("clr_level", fifo_level, 4'd8);

    // Drain back-to-back
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", out_valid, 1'b1);
      chk("drain_seq", out_seq, 16'(i));
      chk("drain_ai", out_ai, 32'hA000_0000 + 32'(i));
      chk("drain_rt", out_rt, 32'hB000_0000 + 32'(i));
      tick();
    end
    chk("drain_empty_valid", out_valid, 1'b0);
    chk("drain_empty_level", fifo_level, 4'd0);
    chk("drain_ai_hold", out_ai, 32'hA000_0007);

    // Next accepted word after drops carries seq 8
    out_ready = 1'b0; hs_data = 64'hCAFEF00D_0BADBEEF; hs_valid = 1'b1;
    tick();
    chk("post_ovf_seq", out_seq, 16'd8);
    chk("post_ovf_ai", out_ai, 32'hCAFEF00D);
    repeat (8) tick();
    chk("refill_level", fifo_level, 4'd8);
    chk("refill_drop", drop_cnt, 16'd1);
    chk("refill_ovf", ovf_sticky, 1'b1);

    // Full FIFO with simultaneous pop and push
    out_ready = 1'b1;
    tick();
    chk("fullpop_level", fifo_level, 4'd8);
    chk("fullpop_drop", drop_cnt, 16'd1);
    chk("fullpop_seq", out_seq, 16'd9);
    hs_valid = 1'b0;
    repeat (3) tick();
    out_ready = 1'b0;
    chk("pre_rst_level", fifo_level, 4'd5);
    chk("pre_rst_seq", out_seq, 16'd12);

    // Asynchronous reset with 5 words queued
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_level", fifo_level, 4'd0);
    chk("arst_drop", drop_cnt, 16'd0);
    chk("arst_ovf", ovf_sticky, 1'b0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1; hs_data = 64'h01234567_89ABCDEF; hs_valid = 1'b1;
    tick();
    hs_valid = 1'b0;
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_seq", out_seq, 16'd0);
    chk("post_rst_rt", out_rt, 32'h89ABCDEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
